// File: rtl/gpr_writeback.sv
// -----------------------------------------------------------------------------
// gpr_writeback
//
// Write-side front end for the 8 x DW general purpose register file.
// Collects ALU results (single cycle, never stalled) and load results
// (buffered in a QDEPTH-entry FIFO), arbitrates them onto the register file's
// single write port and keeps a per-register pending scoreboard for the issue
// stage's RAW/WAW stall logic.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid, iss_dest       issued instruction with a register result
//   alu_valid/dest/data       ALU result, no backpressure
//   ld_valid/dest/data        load result offered to the FIFO
//   ld_ready                  FIFO can accept a load this cycle
//   write_en/dest/data        registered register-file write port
//   pending[7:0]              bit i set: a write to ri is outstanding
//   q_count[QAW:0]            FIFO occupancy, 0..QDEPTH
//
// Optional build macro:
//   GPR_WB_TRACE_EN           prints one line per registered write or
//                             per result dropped because its dest is r0
// -----------------------------------------------------------------------------
module gpr_writeback #(
    parameter int DW     = 16,
    parameter int QDEPTH = 4,
    parameter int QAW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [2:0]    iss_dest,
    input  logic          alu_valid,
    input  logic [2:0]    alu_dest,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    input  logic [2:0]    ld_dest,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          write_en,
    output logic [2:0]    write_dest,
    output logic [DW-1:0] write_data,
    output logic [7:0]    pending,
    output logic [QAW:0]  q_count
);

    // Load handshake: a load transfers on a rising edge where ld_valid and
    // ld_ready are both high. ld_ready depends only on FIFO occupancy, never
    // on ld_valid; while it is low the producer holds dest/data stable.
    localparam logic [QAW:0] QFULL = (QAW+1)'(QDEPTH);

    logic [2:0]     q_dest [QDEPTH];
    logic [DW-1:0]  q_data [QDEPTH];
    logic [QAW-1:0] head;
    logic [QAW-1:0] tail;

    logic           push;
    logic           pop;
    logic           slot_valid;
    logic [2:0]     slot_dest;
    logic [DW-1:0]  slot_data;
    logic           slot_write;
    logic [7:0]     pending_next;

    assign ld_ready = (q_count < QFULL);
    assign push     = ld_valid && ld_ready;
    // The ALU owns the slot whenever it is valid; loads wait behind it.
    assign pop      = !alu_valid && (q_count != '0);

    always_comb begin
        slot_valid = 1'b0;
        slot_dest  = alu_dest;
        slot_data  = alu_data;
        if (alu_valid) begin
            slot_valid = 1'b1;
        end else if (pop) begin
            slot_valid = 1'b1;
            slot_dest  = q_dest[head];
            slot_data  = q_data[head];
        end
    end

    // A result aimed at r0 still consumes the slot but never strobes a write.
    assign slot_write = slot_valid && (slot_dest != 3'd0);

    // Clear for the write retiring this cycle first, then set for the new
    // issue, so a same-register set/clear on one edge leaves the bit set.
    always_comb begin
        pending_next = pending;
        if (write_en) begin
            pending_next[write_dest] = 1'b0;
        end
        if (iss_valid && (iss_dest != 3'd0)) begin
            pending_next[iss_dest] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // FIFO storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            q_dest[tail] <= ld_dest;
            q_data[tail] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            q_count    <= '0;
            write_en   <= 1'b0;
            write_dest <= 3'd0;
            write_data <= '0;
            pending    <= 8'h00;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase

            // Address and data hold their last written values on idle slots.
            write_en <= slot_write;
            if (slot_write) begin
                write_dest <= slot_dest;
                write_data <= slot_data;
            end

            pending <= pending_next;
        end
    end

`ifdef GPR_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && slot_valid) begin
            if (slot_write) begin
                $display("%0t WB %s r%0d=%h q_count=%0d", $time,
                         alu_valid ? "ALU" : "LD", slot_dest, slot_data, q_count);
            end else begin
                $display("%0t WB DROP %s r0=%h q_count=%0d", $time,
                         alu_valid ? "ALU" : "LD", slot_data, q_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// -----------------------------------------------------------------------------
// tb_gpr_writeback
//
// Self-checking bench for gpr_writeback: directed scenarios plus a randomized
// run checked cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_gpr_writeback;

    localparam int DW     = 16;
    localparam int QDEPTH = 4;
    localparam int QAW    = 2;
    localparam int EW     = DW + 3;   // {dest, data}

    // ---------------------------------------------------------------- clock/reset
    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [2:0]    iss_dest;
    logic          alu_valid;
    logic [2:0]    alu_dest;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic [2:0]    ld_dest;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          write_en;
    logic [2:0]    write_dest;
    logic [DW-1:0] write_data;
    logic [7:0]    pending;
    logic [QAW:0]  q_count;

    always #5 clk = ~clk;

    gpr_writeback #(.DW(DW), .QDEPTH(QDEPTH), .QAW(QAW)) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_dest   (iss_dest),
        .alu_valid  (alu_valid),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_dest    (ld_dest),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .write_en   (write_en),
        .write_dest (write_dest),
        .write_data (write_data),
        .pending    (pending),
        .q_count    (q_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------------------------------------------------------- reference model
    // Load buffer as a plain queue; one call per clock edge.
    logic [EW-1:0] m_q[$];
    logic          m_wen   = 1'b0;
    logic [2:0]    m_wdest = 3'd0;
    logic [DW-1:0] m_wdata = '0;
    logic [7:0]    m_pend  = 8'h00;

    task automatic model_step();
        logic          accept;
        logic          have;
        logic [EW-1:0] slot;
        if (rst) begin
            m_q.delete();
            m_wen   = 1'b0;
            m_wdest = 3'd0;
            m_wdata = '0;
            m_pend  = 8'h00;
            return;
        end
        accept = ld_valid && (m_q.size() < QDEPTH);
        if (m_wen) m_pend[m_wdest] = 1'b0;
        if (iss_valid && iss_dest != 3'd0) m_pend[iss_dest] = 1'b1;
        have = 1'b0;
        slot = '0;
        if (alu_valid) begin
            slot = {alu_dest, alu_data};
            have = 1'b1;
        end else if (m_q.size() != 0) begin
            slot = m_q.pop_front();
            have = 1'b1;
        end
        if (have && slot[EW-1:DW] != 3'd0) begin
            m_wen   = 1'b1;
            m_wdest = slot[EW-1:DW];
            m_wdata = slot[DW-1:0];
        end else begin
            m_wen = 1'b0;
        end
        if (accept) m_q.push_back({ld_dest, ld_data});
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        iss_valid = 1'b0; iss_dest = 3'd0;
        alu_valid = 1'b0; alu_dest = 3'd0; alu_data = '0;
        ld_valid  = 1'b0; ld_dest  = 3'd0; ld_data  = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        ld_valid = 1'b1; ld_dest = 3'd2; ld_data = 16'hBEEF;
        tick();
        tick();
        rst = 1'b0;
        ld_valid = 1'b0;
        n_tests++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en got=%b exp=0", write_en); end
        n_tests++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got=%h exp=00", pending); end
        n_tests++; if (q_count !== '0) begin n_fail++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
        n_tests++; if (write_dest !== 3'd0 || write_data !== '0) begin n_fail++; $display("FAIL reset_write_port got=%0d/%h exp=0/0000", write_dest, write_data); end
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    endtask

    task automatic test_alu();
        do_reset();
        iss_valid = 1'b1; iss_dest = 3'd3;
        tick();
        drive_idle();
        n_tests++; if (pending !== 8'h08) begin n_fail++; $display("FAIL alu_pending_set got=%h exp=08", pending); end
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        tick();
        drive_idle();
        n_tests++; if (write_en !== 1'b1 || write_dest !== 3'd3 || write_data !== 16'h1234) begin
            n_fail++; $display("FAIL alu_write got=%b/%0d/%h exp=1/3/1234", write_en, write_dest, write_data); end
        n_tests++; if (pending !== 8'h08) begin n_fail++; $display("FAIL alu_pending_hold got=%h exp=08", pending); end
        tick();
        n_tests++; if (pending !== 8'h00 || write_en !== 1'b0) begin
            n_fail++; $display("FAIL alu_pending_clear got=%h/%b exp=00/0", pending, write_en); end
    endtask

    task automatic test_load_order();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] obs_q[$];
        logic [EW-1:0] loads [3];
        int first_wr = -1;
        int peak = 0;
        int m_peak = 0;
        do_reset();
        loads[0] = {3'd1, 16'd5};
        loads[1] = {3'd2, 16'd6};
        loads[2] = {3'd4, 16'd7};
        for (int i = 0; i < 3; i++) exp_q.push_back(loads[i]);
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                ld_valid = 1'b1; ld_dest = loads[c][EW-1:DW]; ld_data = loads[c][DW-1:0];
            end else begin
                ld_valid = 1'b0;
            end
            tick();
            if (write_en) begin
                obs_q.push_back({write_dest, write_data});
                if (first_wr < 0) first_wr = c;
            end
            if (int'(q_count) > peak) peak = int'(q_count);
            if (m_q.size() > m_peak) m_peak = m_q.size();
        end
        // First accept is on tick 0; its write must be visible after tick 1.
        n_tests++; if (first_wr !== 1) begin n_fail++; $display("FAIL load_latency got=%0d exp=1", first_wr); end
        n_tests++; if (peak !== m_peak) begin n_fail++; $display("FAIL load_peak got=%0d exp=%0d", peak, m_peak); end
        n_tests++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL load_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL load_order[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_priority();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] obs_q[$];
        logic [EW-1:0] alus  [6];
        logic [EW-1:0] loads [4];
        int  li = 0;
        logic rdy;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alus[i] = {3'($urandom_range(1, 7)), 16'($urandom)};
            exp_q.push_back(alus[i]);
        end
        for (int i = 0; i < 4; i++) begin
            loads[i] = {3'($urandom_range(1, 7)), 16'($urandom)};
            exp_q.push_back(loads[i]);
        end
        for (int c = 0; c < 20; c++) begin
            alu_valid = (c < 6);
            alu_dest  = (c < 6) ? alus[c][EW-1:DW] : 3'd0;
            alu_data  = (c < 6) ? alus[c][DW-1:0] : '0;
            ld_valid  = (li < 4);
            ld_dest   = (li < 4) ? loads[li][EW-1:DW] : 3'd0;
            ld_data   = (li < 4) ? loads[li][DW-1:0] : '0;
            rdy = ld_ready;
            tick();
            if (ld_valid && rdy) li++;
            if (write_en) obs_q.push_back({write_dest, write_data});
            if (c == 4) begin
                n_tests++; if (q_count !== 3'd4 || ld_ready !== 1'b0) begin
                    n_fail++; $display("FAIL full_ready got=q%0d/r%b exp=q4/r0", q_count, ld_ready); end
            end
        end
        drive_idle();
        n_tests++; if (li !== 4) begin n_fail++; $display("FAIL full_accepted got=%0d exp=4", li); end
        n_tests++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL full_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_r0_corner();
        do_reset();
        iss_valid = 1'b1; iss_dest = 3'd0;
        tick();
        drive_idle();
        n_tests++; if (pending !== 8'h00) begin n_fail++; $display("FAIL r0_iss got=%h exp=00", pending); end
        alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'hDEAD;
        tick();
        drive_idle();
        n_tests++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL r0_alu_write_en got=%b exp=0", write_en); end
        iss_valid = 1'b1; iss_dest = 3'd5;
        tick();
        drive_idle();
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h0A5A;
        tick();
        drive_idle();
        n_tests++; if (write_en !== 1'b1 || write_dest !== 3'd5) begin
            n_fail++; $display("FAIL r5_write got=%b/%0d exp=1/5", write_en, write_dest); end
        // Re-issue r5 on the edge that retires the previous r5 write.
        iss_valid = 1'b1; iss_dest = 3'd5;
        tick();
        drive_idle();
        n_tests++; if (pending !== 8'h20) begin n_fail++; $display("FAIL set_wins got=%h exp=20", pending); end
    endtask

    task automatic test_reset_mid();
        int late_writes = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            iss_valid = 1'b1;
            iss_dest  = (c == 0) ? 3'd2 : (c == 1) ? 3'd3 : 3'd5;
            alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'(c);
            ld_valid  = 1'b1; ld_dest = (c == 0) ? 3'd6 : (c == 1) ? 3'd7 : 3'd1;
            ld_data   = 16'h1000 + 16'(c);
            tick();
        end
        drive_idle();
        n_tests++; if (q_count !== 3'd3 || pending !== 8'h2C) begin
            n_fail++; $display("FAIL mid_setup got=q%0d/p%h exp=q3/p2c", q_count, pending); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (q_count !== '0 || pending !== 8'h00 || write_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got=q%0d/p%h/w%b exp=q0/p00/w0", q_count, pending, write_en); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (write_en) late_writes++;
        end
        n_tests++; if (late_writes !== 0) begin n_fail++; $display("FAIL mid_discard got=%0d exp=0", late_writes); end
    endtask

    task automatic test_random();
        logic rdy;
        int   errs = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_dest  = 3'($urandom_range(0, 7));
            alu_valid = ($urandom_range(0, 9) < 3);
            alu_dest  = 3'($urandom_range(0, 7));
            alu_data  = 16'($urandom);
            // Producer keeps an unaccepted load stable until it goes through.
            if (!ld_valid) begin
                ld_valid = ($urandom_range(0, 9) < 6);
                ld_dest  = 3'($urandom_range(0, 7));
                ld_data  = 16'($urandom);
            end
            rdy = ld_ready;
            tick();
            if (ld_valid && (rdy || rst)) ld_valid = 1'b0;
            n_tests++;
            if (write_en !== m_wen || write_dest !== m_wdest || write_data !== m_wdata ||
                pending !== m_pend || q_count !== (QAW+1)'(m_q.size()) ||
                ld_ready !== (m_q.size() < QDEPTH)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d] got=w%b d%0d %h p%h q%0d r%b exp=w%b d%0d %h p%h q%0d r%b",
                             c, write_en, write_dest, write_data, pending, q_count, ld_ready,
                             m_wen, m_wdest, m_wdata, m_pend, m_q.size(), (m_q.size() < QDEPTH));
            end
        end
        rst = 1'b0;
        drive_idle();
    endtask

    // ---------------------------------------------------------------- sequence + report
    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_alu();
        test_load_order();
        test_full_priority();
        test_r0_corner();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
